seq_generator: RTL and testbench

- Serial pattern transmitter: loads a PAT_W-bit pattern plus length, repeat and gap settings, then drives it MSB-first onto a one-bit serial line at one bit per clk.
- Acts as the stimulus/transmit end for the team's serial sequence detectors; its output feeds a detector's serial input directly.
- Start/ready/done handshake for a controlling FSM or testbench, plus an abort path.

---
 rtl/seq_pkg.sv | 32 +++
 rtl/seq_down_counter.sv | 31 +++
 rtl/seq_generator.sv | 177 +++++++++++++++++
 tb/tb_seq_generator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the detector tests
// that consume its output.
package seq_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Line level when no pattern bit is on the wire
    localparam logic IDLE_LVL_DEFAULT = 1'b0;

    // Canonical 3-bit target sequence used by the detector tests
    localparam logic [2:0] TARGET_101 = 3'b101;

    // Slots of the down-counter bank inside the generator
    localparam int CTR_IDX = 0;
    localparam int CTR_REP = 1;
    localparam int CTR_GAP = 2;
    localparam int NUM_CTR = 3;

    // Largest of three widths; sizes the shared counter bank
    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag. Load has priority over decrement,
// and decrement saturates at zero so the count can never wrap.
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Count register: reset clears, load overrides, decrement stops at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends the low len bits of a captured pattern
// MSB-first, reps+1 times, with gap idle cycles between copies.
module seq_generator
    import seq_pkg::*;
#(
    parameter int   PAT_W    = 8,
    parameter int   LEN_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_LVL = IDLE_LVL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             a,
    output logic             bit_valid,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    // All three counters share one width so they can live in one bank
    localparam int CW = max3(LEN_W, CNT_W, GAP_W);

    state_t           state_reg, state_next;
    logic [PAT_W-1:0] pat_reg;
    logic [LEN_W-1:0] len_reg;
    logic [GAP_W-1:0] gap_reg;
    logic             a_reg, a_next;
    logic             bit_valid_reg, bit_valid_next;
    logic             ready_reg, busy_reg, done_reg;
    logic             accept;
    logic [LEN_W-1:0] len_eff;
    logic [PAT_W-1:0] bit_src;
    logic [CW-1:0]    bit_sel;
    logic [PAT_W-1:0] bit_mask;

    logic             ctr_load     [NUM_CTR];
    logic             ctr_dec      [NUM_CTR];
    logic [CW-1:0]    ctr_load_val [NUM_CTR];
    logic [CW-1:0]    ctr_count    [NUM_CTR];
    logic             ctr_zero     [NUM_CTR];

    // A length of zero or one wider than the pattern means "whole pattern"
    assign len_eff = ((len == '0) || (len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : len;

    // Counter bank: bit index, remaining repetitions, remaining gap cycles
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTR; gi++) begin : g_ctr
            seq_down_counter #(.W(CW)) u_ctr (
                .clk      (clk),
                .rst      (rst),
                .load     (ctr_load[gi]),
                .load_val (ctr_load_val[gi]),
                .dec      (ctr_dec[gi]),
                .count    (ctr_count[gi]),
                .zero     (ctr_zero[gi])
            );
        end
    endgenerate

    // Next-state logic; also picks which pattern bit goes onto the line next
    always_comb begin
        state_next     = state_reg;
        bit_valid_next = 1'b0;
        accept         = 1'b0;
        bit_src        = pat_reg;
        bit_sel        = ctr_count[CTR_IDX] - 1'b1;
        for (int i = 0; i < NUM_CTR; i++) begin
            ctr_load[i] = 1'b0;
            ctr_dec[i]  = 1'b0;
        end
        ctr_load_val[CTR_IDX] = CW'(len_reg - 1'b1);
        ctr_load_val[CTR_REP] = CW'(reps);
        ctr_load_val[CTR_GAP] = CW'(gap_reg - 1'b1);

        case (state_reg)
            ST_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    accept                = 1'b1;
                    state_next            = ST_SHIFT;
                    ctr_load[CTR_IDX]     = 1'b1;
                    ctr_load[CTR_REP]     = 1'b1;
                    ctr_load_val[CTR_IDX] = CW'(len_eff - 1'b1);
                    bit_src               = pattern;
                    bit_sel               = CW'(len_eff - 1'b1);
                    bit_valid_next        = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (ctr_zero[CTR_IDX]) begin
                    if (ctr_zero[CTR_REP]) begin
                        state_next = ST_DONE;
                    end else begin
                        ctr_dec[CTR_REP] = 1'b1;
                        if (gap_reg != '0) begin
                            state_next        = ST_GAP;
                            ctr_load[CTR_GAP] = 1'b1;
                        end else begin
                            // back-to-back copy: reload without an idle cycle
                            ctr_load[CTR_IDX] = 1'b1;
                            bit_sel           = CW'(len_reg - 1'b1);
                            bit_valid_next    = 1'b1;
                        end
                    end
                end else begin
                    ctr_dec[CTR_IDX] = 1'b1;
                    bit_valid_next   = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (ctr_zero[CTR_GAP]) begin
                    state_next        = ST_SHIFT;
                    ctr_load[CTR_IDX] = 1'b1;
                    bit_sel           = CW'(len_reg - 1'b1);
                    bit_valid_next    = 1'b1;
                end else begin
                    ctr_dec[CTR_GAP] = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        bit_mask = PAT_W'(1) << bit_sel;
        a_next   = bit_valid_next ? (|(bit_src & bit_mask)) : IDLE_LVL;
    end

    // State, registered outputs and captured transfer settings
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            a_reg         <= IDLE_LVL;
            bit_valid_reg <= 1'b0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pat_reg       <= '0;
            len_reg       <= '0;
            gap_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            bit_valid_reg <= bit_valid_next;
            ready_reg     <= (state_next == ST_IDLE);
            busy_reg      <= (state_next == ST_SHIFT) || (state_next == ST_GAP);
            done_reg      <= (state_next == ST_DONE);
            if (accept) begin
                pat_reg <= pattern;
                len_reg <= len_eff;
                gap_reg <= gap;
            end
        end
    end

    assign a         = a_reg;
    assign bit_valid = bit_valid_reg;
    assign ready     = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_seq_generator.sv
// Scoreboard bench for seq_generator: stimulus pushes expected bits and done
// cycles, a negedge monitor pops and compares whenever the DUT presents them.
module tb_seq_generator;
    import seq_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       a;
    logic       bit_valid;
    logic       ready;
    logic       busy;
    logic       done;

    typedef struct {
        int   cyc;
        logic val;
    } exp_bit_t;

    exp_bit_t bit_q[$];
    int       done_q[$];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;
    int       t0;

    seq_generator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .len       (len),
        .reps      (reps),
        .gap       (gap),
        .a         (a),
        .bit_valid (bit_valid),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every presented bit / done pulse against the scoreboard
    always @(negedge clk) begin
        exp_bit_t e;
        int       d;
        if (bit_valid === 1'b1) begin
            if (bit_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_bit at cycle %0d: got a=%0b, expected no bit", cyc, a);
            end else begin
                e = bit_q.pop_front();
                check("bit_cycle", cyc, e.cyc);
                check("bit_value", a, e.val);
                $display("bit   cycle %0d a=%0b (exp %0b @ %0d)", cyc, a, e.val, e.cyc);
            end
        end else begin
            check("idle_level", a, 0);
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done at cycle %0d: got done=1, expected 0", cyc);
            end else begin
                d = done_q.pop_front();
                check("done_cycle", cyc, d);
                check("done_not_busy", busy, 0);
                $display("done  cycle %0d (exp %0d)", cyc, d);
            end
        end
    end

    // Issue one transfer: push expected bits (up to max_bits) and done cycle, then pulse start
    task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                          input logic [3:0] g, input logic [7:0] ebits, input int nb,
                          input int max_bits, input int done_rel, output int t_start);
        exp_bit_t e;
        int       k;
        t_start = cyc;
        k = 0;
        for (int ri = 0; ri <= int'(r); ri++) begin
            for (int i = 0; i < nb; i++) begin
                if (k < max_bits) begin
                    e.cyc = t_start + 1 + ri * (nb + int'(g)) + i;
                    e.val = ebits[nb-1-i];
                    bit_q.push_back(e);
                end
                k++;
            end
        end
        if (done_rel >= 0) done_q.push_back(t_start + done_rel);
        $display("start cycle %0d pattern=%02h len=%0d reps=%0d gap=%0d", t_start, p, l, r, g);
        pattern = p;
        len     = l;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        logic [7:0] tgt;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", bit_valid, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", ready, 1);
            check("idle_busy", busy, 0);
        end

        // Basic 101 send, done at 4, ready back at 5
        tgt = {5'b0, TARGET_101};
        launch(8'b0000_0101, 4'd3, 4'd0, 4'd0, tgt, 3, 99, 4, t0);
        wait_until(t0 + 4);
        check("basic_ready_in_done", ready, 0);
        wait_until(t0 + 5);
        check("basic_ready_after", ready, 1);
        check("basic_busy_after", busy, 0);
        repeat (2) @(negedge clk);

        // Three copies with 3-cycle gaps, done at 31
        launch(8'b1011_0000, 4'd8, 4'd2, 4'd3, 8'b1011_0000, 8, 99, 31, t0);
        wait_until(t0 + 10);
        check("gap_busy", busy, 1);
        check("gap_valid", bit_valid, 0);
        check("gap_ready", ready, 0);
        wait_until(t0 + 33);

        // len=0 means full width
        launch(8'hA5, 4'd0, 4'd0, 4'd0, 8'hA5, 8, 99, 9, t0);
        wait_until(t0 + 11);
        // len wider than the pattern also means full width
        launch(8'h3C, 4'd12, 4'd0, 4'd0, 8'h3C, 8, 99, 9, t0);
        wait_until(t0 + 11);
        // len=1, four copies back to back
        launch(8'h01, 4'd1, 4'd3, 4'd0, 8'h01, 1, 99, 5, t0);
        wait_until(t0 + 7);
        // maximum reps must not wrap: 16 copies, done at 17
        launch(8'h01, 4'd1, 4'd15, 4'd0, 8'h01, 1, 99, 17, t0);
        wait_until(t0 + 19);

        // Abort at cycle 4: four bits out, IDLE at 5, no done
        launch(8'hC3, 4'd8, 4'd0, 4'd0, 8'hC3, 8, 4, -1, t0);
        wait_until(t0 + 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_valid", bit_valid, 0);
        repeat (3) @(negedge clk);

        // Starts while busy and while in DONE are ignored
        launch(8'b0000_0101, 4'd3, 4'd0, 4'd0, 8'b0000_0101, 3, 99, 4, t0);
        wait_until(t0 + 2);
        pattern = 8'hFF;
        len     = 4'd8;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_until(t0 + 4);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("ign_ready_after", ready, 1);
        @(negedge clk);
        check("ign_no_restart", bit_valid, 0);
        check("ign_ready_stays", ready, 1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a transfer
        launch(8'hFF, 4'd8, 4'd0, 4'd0, 8'hFF, 8, 3, -1, t0);
        wait_until(t0 + 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_valid", bit_valid, 0);
        check("midrst_a", a, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // start together with abort in IDLE: nothing captured
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_ready", ready, 1);
        check("sa_busy", busy, 0);
        @(negedge clk);
        check("sa_valid", bit_valid, 0);
        check("sa_ready2", ready, 1);
        repeat (3) @(negedge clk);

        check("bits_drained", bit_q.size(), 0);
        check("dones_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
